// File: rtl/frame_pkg.sv
// Shared types and constants for the framed serial byte sequencer.
package frame_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_WORD_DEFAULT = 8'hA5;

  typedef enum logic {
    HUNT,
    CAPTURE
  } state_t;

endpackage

// File: rtl/sync_detect.sv
// Sliding 8-bit sync window with a saturating fill count; flags a match only
// once a full window of fresh bits has been seen.
module sync_detect
  import frame_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  input  logic shift_en,
  output logic match
);

  logic [BYTE_W-1:0] window;
  logic [BYTE_W-1:0] next_window;
  logic [3:0]        fill;

  assign next_window = {in, window[BYTE_W-1:1]};
  // fill >= 7 here means this edge delivers the 8th fresh bit
  assign match = shift_en && (fill >= 4'd7) && (next_window == SYNC_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window <= '0;
      fill   <= '0;
    end else if (!shift_en) begin
      window <= '0;
      fill   <= '0;
    end else begin
      window <= next_window;
      if (fill != 4'd8) fill <= fill + 4'd1;
    end
  end

endmodule

// File: rtl/frame_seq_ctrl.sv
// Serial frame sequencer: hunts for a sync word, then captures FRAME_BYTES
// LSB-first bytes and hands them out over a valid/ready register.
module frame_seq_ctrl
  import frame_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
  parameter int unsigned       FRAME_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in,
  input  logic              enable,
  input  logic              clr_overrun,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              overrun,
  output logic              busy
);

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        byte_cnt;
  logic [BYTE_W-1:0] shreg;
  logic              match;
  logic              byte_done;
  logic [BYTE_W-1:0] completed;

  sync_detect #(
    .SYNC_WORD (SYNC_WORD)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .shift_en ((state == HUNT) && enable),
    .match    (match)
  );

  assign byte_done = (state == CAPTURE) && enable && (bit_cnt == 3'd7);
  assign completed = {in, shreg[BYTE_W-2:0]};
  assign busy      = (state == CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      shreg       <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;

      case (state)
        HUNT: begin
          if (match) begin
            state       <= CAPTURE;
            frame_start <= 1'b1;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
          end
        end
        CAPTURE: begin
          if (!enable) begin
            state       <= HUNT;
            frame_abort <= 1'b1;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
          end else begin
            shreg[bit_cnt] <= in;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_cnt <= byte_cnt + 8'd1;
              if (byte_cnt == LAST_BYTE) begin
                state      <= HUNT;
                frame_done <= 1'b1;
                byte_cnt   <= '0;
              end
            end
          end
        end
        default: state <= HUNT;
      endcase

      // A completing byte may replace an accepted one; it is dropped only
      // when the held byte is still unconsumed.
      if (byte_done) begin
        if (!byte_valid || byte_ready) begin
          byte_data  <= completed;
          byte_valid <= 1'b1;
        end
      end else if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end

      if (byte_done && byte_valid && !byte_ready) overrun <= 1'b1;
      else if (clr_overrun)                       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Randomized and directed bench for frame_seq_ctrl against a bit-history model.
module tb_frame_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_in = 1'b0;
  logic enable = 1'b0;
  logic byte_ready = 1'b0;
  logic clr_overrun = 1'b0;

  logic [7:0] data0, data1;
  logic valid0, start0, done0, abort0, ovr0, busy0;
  logic valid1, start1, done1, abort1, ovr1, busy1;

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  frame_seq_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .in(bit_in), .enable(enable), .clr_overrun(clr_overrun),
    .byte_data(data0), .byte_valid(valid0), .byte_ready(byte_ready),
    .frame_start(start0), .frame_done(done0), .frame_abort(abort0),
    .overrun(ovr0), .busy(busy0)
  );

  frame_seq_ctrl #(.SYNC_WORD(8'h80), .FRAME_BYTES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in(bit_in), .enable(enable), .clr_overrun(clr_overrun),
    .byte_data(data1), .byte_valid(valid1), .byte_ready(byte_ready),
    .frame_start(start1), .frame_done(done1), .frame_abort(abort1),
    .overrun(ovr1), .busy(busy1)
  );

  // Reference model: per instance, the list of bits seen while hunting
  // (oldest first = bit 0) and the bits gathered for the current byte.
  logic [7:0] sw [2] = '{8'hA5, 8'h80};
  int         fb [2] = '{4, 1};
  bit         m_hunt [2];
  int         m_hn [2];
  bit         m_hist [2][8];
  int         m_capn [2];
  int         m_capv [2];
  int         m_nby [2];
  logic [7:0] e_data [2];
  bit         e_valid [2];
  bit         e_start [2];
  bit         e_done [2];
  bit         e_abort [2];
  bit         e_ovr [2];

  task automatic check_val(string tag, logic [7:0] obs, logic [7:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_hunt[m] = 1; m_hn[m] = 0; m_capn[m] = 0; m_capv[m] = 0; m_nby[m] = 0;
      e_data[m] = 8'h00; e_valid[m] = 0; e_start[m] = 0;
      e_done[m] = 0; e_abort[m] = 0; e_ovr[m] = 0;
    end
  endtask

  task automatic model_step(int m, bit b, bit en, bit rdy, bit clr);
    bit newb = 0;
    bit ovr_set = 0;
    int val = 0;
    int word = 0;
    e_start[m] = 0; e_done[m] = 0; e_abort[m] = 0;
    if (m_hunt[m]) begin
      if (!en) m_hn[m] = 0;
      else begin
        for (int i = 0; i < 7; i++) m_hist[m][i] = m_hist[m][i+1];
        m_hist[m][7] = b;
        if (m_hn[m] < 8) m_hn[m]++;
        for (int i = 0; i < 8; i++) word += int'(m_hist[m][i]) * (1 << i);
        if (m_hn[m] == 8 && word == int'(sw[m])) begin
          e_start[m] = 1; m_hunt[m] = 0; m_hn[m] = 0;
          m_capn[m] = 0; m_capv[m] = 0; m_nby[m] = 0;
        end
      end
    end else if (!en) begin
      e_abort[m] = 1; m_hunt[m] = 1; m_hn[m] = 0;
    end else begin
      m_capv[m] += int'(b) * (1 << m_capn[m]);
      m_capn[m]++;
      if (m_capn[m] == 8) begin
        newb = 1; val = m_capv[m];
        m_capn[m] = 0; m_capv[m] = 0;
        m_nby[m]++;
        if (m_nby[m] == fb[m]) begin
          e_done[m] = 1; m_hunt[m] = 1; m_hn[m] = 0;
        end
      end
    end
    if (newb) begin
      if (!e_valid[m] || rdy) begin
        e_data[m] = val[7:0];
        e_valid[m] = 1;
      end else ovr_set = 1;
    end else if (e_valid[m] && rdy) e_valid[m] = 0;
    if (ovr_set) e_ovr[m] = 1;
    else if (clr) e_ovr[m] = 0;
  endtask

  task automatic compare_all();
    check_val("data0",  data0,       e_data[0]);
    check_val("valid0", 8'(valid0),  8'(e_valid[0]));
    check_val("start0", 8'(start0),  8'(e_start[0]));
    check_val("done0",  8'(done0),   8'(e_done[0]));
    check_val("abort0", 8'(abort0),  8'(e_abort[0]));
    check_val("ovr0",   8'(ovr0),    8'(e_ovr[0]));
    check_val("busy0",  8'(busy0),   8'(!m_hunt[0]));
    check_val("data1",  data1,       e_data[1]);
    check_val("valid1", 8'(valid1),  8'(e_valid[1]));
    check_val("start1", 8'(start1),  8'(e_start[1]));
    check_val("done1",  8'(done1),   8'(e_done[1]));
    check_val("abort1", 8'(abort1),  8'(e_abort[1]));
    check_val("ovr1",   8'(ovr1),    8'(e_ovr[1]));
    check_val("busy1",  8'(busy1),   8'(!m_hunt[1]));
  endtask

  task automatic cyc(bit b, bit en, bit rdy, bit clr);
    bit_in = b; enable = en; byte_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    model_step(0, b, en, rdy, clr);
    model_step(1, b, en, rdy, clr);
    @(negedge clk);
    compare_all();
  endtask

  // Ready is rdy_early for bits 0..6 and rdy_last on the bit-7 edge.
  task automatic send_byte(logic [7:0] v, bit rdy_early, bit rdy_last);
    for (int i = 0; i < 8; i++) cyc(v[i], 1'b1, (i == 7) ? rdy_last : rdy_early, 1'b0);
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, rdy, 1'b0);
  endtask

  // Reset asserted between edges must clear outputs without a clock edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3 compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 7 zeros then A5 and a full frame with the consumer always ready
    idle(7, 1'b1);
    send_byte(8'hA5, 1'b1, 1'b1);
    send_byte(8'h3C, 1'b1, 1'b1);
    send_byte(8'h81, 1'b1, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b1);
    send_byte(8'h00, 1'b1, 1'b1);
    idle(10, 1'b1);

    // consumer stalled: bytes after 3C are dropped, then overrun is cleared
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'h81, 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    idle(10, 1'b1);

    // ready raised exactly on the edge that completes 81
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'h81, 1'b0, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b1);
    send_byte(8'h00, 1'b1, 1'b1);
    idle(10, 1'b1);

    // abort after 2 bytes plus 3 bits, then a clean restart
    send_byte(8'hA5, 1'b1, 1'b1);
    send_byte(8'h3C, 1'b1, 1'b1);
    send_byte(8'h81, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    idle(8, 1'b1);
    send_byte(8'hA5, 1'b1, 1'b1);
    send_byte(8'h12, 1'b1, 1'b1);
    send_byte(8'h34, 1'b1, 1'b1);
    send_byte(8'h56, 1'b1, 1'b1);
    send_byte(8'h78, 1'b1, 1'b1);
    idle(4, 1'b1);

    // reset mid-byte, then a lone 1 must not match 80 on an empty window
    send_byte(8'hA5, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    async_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    idle(9, 1'b1);

    for (int s = 0; s < 400; s++) begin
      logic [7:0] pat;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 3)      pat = 8'hA5;
      else if (sel < 5) pat = 8'h80;
      else              pat = 8'($urandom);
      for (int i = 0; i < 8; i++)
        cyc(pat[i], ($urandom_range(0, 99) >= 3), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 99) < 4));
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
